// File: rtl/ad5628_spi_responder.sv
// AD5628 octal DAC serial-interface responder: oversamples sclk/sync_n/din/ldac_n in the clk
// domain, decodes 32-bit frames and maintains per-channel input and DAC registers.
module ad5628_spi_responder #(
    parameter int unsigned   N_CH     = 8,
    parameter int unsigned   DW       = 12,
    parameter int unsigned   SYNC_STG = 2,
    parameter logic [DW-1:0] RST_CODE = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sclk,
    input  logic               sync_n,
    input  logic               din,
    input  logic               ldac_n,
    output logic               frame_valid,
    output logic               frame_err,
    output logic [3:0]         cmd,
    output logic [3:0]         addr,
    output logic [DW-1:0]      data,
    output logic [N_CH*DW-1:0] dac_out
);

    localparam int unsigned CW = 6;
    localparam int unsigned FW = 31;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, WAIT} state_t;

    state_t                   state_q, state_nxt;
    logic [CW-1:0]            count_q, count_nxt;
    logic [FW-1:0]            shift_q, shift_nxt;
    logic                     fv_nxt, fe_nxt, commit;
    logic [N_CH-1:0][DW-1:0]  in_q, in_nxt;
    logic [N_CH-1:0][DW-1:0]  dac_q, dac_nxt;

    // pin synchronisers, lanes {ldac_n, din, sync_n, sclk}; reset to the idle bus levels
    logic [SYNC_STG-1:0][3:0] pin_sync;
    logic                     sclk_prev;
    logic                     sclk_s, sync_n_s, din_s, ldac_n_s;
    logic                     sclk_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_sync  <= {SYNC_STG{4'b1011}};
            sclk_prev <= 1'b1;
        end else begin
            pin_sync  <= {pin_sync[SYNC_STG-2:0], {ldac_n, din, sync_n, sclk}};
            sclk_prev <= sclk_s;
        end
    end

    assign {ldac_n_s, din_s, sync_n_s, sclk_s} = pin_sync[SYNC_STG-1];
    assign sclk_fall = sclk_prev & ~sclk_s;

    // bit 31 of the frame is don't-care, so only the low 31 bits are kept
    logic [3:0]    f_cmd, f_addr;
    logic [DW-1:0] f_data;
    assign f_cmd  = shift_q[27:24];
    assign f_addr = shift_q[23:20];
    assign f_data = shift_q[19 -: DW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            shift_q     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            cmd         <= '0;
            addr        <= '0;
            data        <= '0;
            in_q        <= {N_CH{RST_CODE}};
            dac_q       <= {N_CH{RST_CODE}};
        end else begin
            state_q     <= state_nxt;
            count_q     <= count_nxt;
            shift_q     <= shift_nxt;
            frame_valid <= fv_nxt;
            frame_err   <= fe_nxt;
            in_q        <= in_nxt;
            dac_q       <= dac_nxt;
            if (commit) begin
                cmd  <= f_cmd;
                addr <= f_addr;
                data <= f_data;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        count_nxt = count_q;
        shift_nxt = shift_q;
        fv_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!sync_n_s) begin
                    state_nxt = SHIFT;
                    count_nxt = '0;
                end
            end
            SHIFT: begin
                if (sync_n_s) begin
                    fe_nxt    = 1'b1;
                    state_nxt = IDLE;
                end else if (sclk_fall) begin
                    shift_nxt = {shift_q[FW-2:0], din_s};
                    count_nxt = count_q + CW'(1);
                    if (count_q == CW'(31)) state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                fv_nxt    = 1'b1;
                commit    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (sync_n_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // command decode; an LDAC level in the same cycle sees the freshly written input values
    logic all_ch, addr_ok, sel;
    always_comb begin
        in_nxt  = in_q;
        dac_nxt = dac_q;
        all_ch  = (f_addr == 4'hF);
        addr_ok = all_ch;
        sel     = 1'b0;
        for (int k = 0; k < N_CH; k++) addr_ok = addr_ok | (f_addr == 4'(k));
        if (commit && addr_ok) begin
            for (int k = 0; k < N_CH; k++) begin
                sel = all_ch | (f_addr == 4'(k));
                case (f_cmd)
                    4'b0000: if (sel) in_nxt[k] = f_data;
                    4'b0001: if (sel) dac_nxt[k] = in_q[k];
                    4'b0010: if (sel) in_nxt[k] = f_data;
                    4'b0011: if (sel) begin
                        in_nxt[k]  = f_data;
                        dac_nxt[k] = f_data;
                    end
                    default: ;
                endcase
            end
            if (f_cmd == 4'b0010) dac_nxt = in_nxt;
        end
        if (!ldac_n_s) dac_nxt = in_nxt;
    end

    assign dac_out = dac_q;

endmodule
